wb_port_arbiter: RTL
====================

Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between three writeback sources: the single-cycle ALU, the multi-cycle MULT unit and the LOAD unit.
- Buffers MULT and LOAD results in small FIFOs and arbitrates between them round-robin.
- Emits retire pulses (MULT_reg_wr/rd, LOAD_reg_wr/rd) that clear the matching entries in the EXE-stage long-latency hazard scoreboard.
- Sits between EXE/MEM and the regfile; the ALU has top priority, and a starvation guard stalls ALU issue when a long result waits too long.

Parameters:
BUF_DEPTH, 2, entries per long-source FIFO (power of 2, >=2)
STARVE_MAX, 4, wait cycles of a FIFO head before alu_hold is raised (>=1)

Ports:
clk  in  1  clock
rstn  in  1  reset
alu_wr  in  1  ALU result valid this cycle; no backpressure
alu_rd  in  5  ALU destination
alu_data  in  32  ALU result
mult_valid  in  1  MULT result offered
mult_ready  out  1  MULT FIFO not full
mult_rd  in  5  MULT destination
mult_data  in  32  MULT result
load_valid  in  1  LOAD result offered
load_ready  out  1  LOAD FIFO not full
load_rd  in  5  LOAD destination
load_data  in  32  LOAD result
alu_hold  out  1  request pipeline to suppress ALU writeback next cycle
rf_we  out  1  regfile write enable
rf_waddr  out  5  regfile write address
rf_wdata  out  32  regfile write data
MULT_reg_wr  out  1  MULT result retired (scoreboard clear)
MULT_reg_rd  out  5  retired MULT destination
LOAD_reg_wr  out  1  LOAD result retired
LOAD_reg_rd  out  5  retired LOAD destination

Behaviour:
- Reset: rstn is asynchronous and active-low; clock is clk. Reset clears all outputs to 0 (ready outputs read 1 once out of reset), empties FIFOs, zeroes wait counters and sets the RR pointer to favour MULT.
- Handshake: a transfer occurs on valid&ready at a rising edge. Data and rd are captured into the FIFO tail. Valid must not be dropped before ready.
- FIFOs: ready = !full. Simultaneous push and pop on a full FIFO is not permitted (ready is already 0). Push and pop in the same cycle on a non-empty FIFO leaves the count unchanged. Pointers wrap modulo BUF_DEPTH.
- Arbitration, each cycle, from FIFO heads registered at cycle start:
  1. If alu_wr=1, the ALU wins.
  2. Otherwise, if exactly one head is valid, that head wins.
  3. Otherwise, if both heads are valid, the source not granted last wins.
  - The RR pointer updates only on a MULT/LOAD grant.
- Outputs are registered, giving one-cycle latency.
  - ALU: alu_wr at cycle N produces rf_we at N+1.
  - Long sources: a result accepted at cycle N is at the FIFO head at N+1, so the earliest rf_we is N+2.
- Retire pulse: MULT_reg_wr/LOAD_reg_wr pulse for exactly one cycle, in the same cycle as that source's rf_we. rd is carried as-is.
- rd=0: rf_we is forced to 0, but the retire pulse is still issued.
- Starvation guard:
  - Per-source wait counter increments while its head is valid and not granted, saturating at STARVE_MAX, and clears on grant.
  - alu_hold is a registered output, 1 while any counter equals STARVE_MAX.
  - The pipeline guarantees alu_wr=0 in cycles with alu_hold=1. If alu_wr arrives anyway, the ALU still wins (no data loss) and the counter stays saturated.
- No flush input: results already accepted always retire, which keeps the scoreboard consistent.
- Reset mid-operation discards FIFO contents; no retire pulses are emitted.

Optional Feature:
- Macro: WB_PERF_EN.
- When defined, two ports are added:
  - hold_cnt (out, 16): counts cycles with alu_hold=1.
  - conflict_cnt (out, 16): counts cycles where alu_wr=1 and at least one head is valid.
- Both counters are saturating, reset to 0 and read-only.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- alu_wr=1, alu_rd=5, alu_data=0x11 at cycle 0 -> rf_we=1, waddr=5, wdata=0x11 at cycle 1; no retire pulses.
- MULT push rd=7, data=0xAB at cycle 0, no ALU traffic -> cycle 2: rf_we=1, waddr=7; MULT_reg_wr=1, MULT_reg_rd=7 for one cycle.
- MULT and LOAD heads both valid, no ALU -> grants alternate MULT, LOAD, MULT… starting with MULT after reset.
- LOAD head valid, alu_wr=1 continuously, STARVE_MAX=4 -> alu_hold=1 after 4 denied cycles. Releasing alu_wr gives the LOAD write, then alu_hold=0 the next cycle.
- Two MULT pushes with no pop (BUF_DEPTH=2) -> mult_ready=0. A third valid is held until a pop, then accepted; all three retire in order.
- LOAD push rd=0 -> rf_we stays 0, LOAD_reg_wr pulses with LOAD_reg_rd=0. Asserting rstn low mid-stream -> all outputs 0, FIFOs empty.

Source files
------------

// File: rtl/wb_port_arbiter_if.sv
// Writeback-port bundle between the EXE/MEM pipeline (master) and the
// writeback arbiter (slave): ALU/MULT/LOAD result inputs, regfile write
// port and scoreboard retire pulses.
interface wb_port_arbiter_if;
  logic        alu_wr;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;

  logic        mult_valid;
  logic        mult_ready;
  logic [4:0]  mult_rd;
  logic [31:0] mult_data;

  logic        load_valid;
  logic        load_ready;
  logic [4:0]  load_rd;
  logic [31:0] load_data;

  logic        alu_hold;

  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  logic        MULT_reg_wr;
  logic [4:0]  MULT_reg_rd;
  logic        LOAD_reg_wr;
  logic [4:0]  LOAD_reg_rd;

  modport master (
    output alu_wr, alu_rd, alu_data,
    output mult_valid, mult_rd, mult_data,
    output load_valid, load_rd, load_data,
    input  mult_ready, load_ready, alu_hold,
    input  rf_we, rf_waddr, rf_wdata,
    input  MULT_reg_wr, MULT_reg_rd, LOAD_reg_wr, LOAD_reg_rd
  );

  modport slave (
    input  alu_wr, alu_rd, alu_data,
    input  mult_valid, mult_rd, mult_data,
    input  load_valid, load_rd, load_data,
    output mult_ready, load_ready, alu_hold,
    output rf_we, rf_waddr, rf_wdata,
    output MULT_reg_wr, MULT_reg_rd, LOAD_reg_wr, LOAD_reg_rd
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: shares the single regfile write port between the
// ALU (top priority, no backpressure) and the buffered MULT/LOAD sources
// (round-robin between them). Emits scoreboard retire pulses alongside each
// long-latency write and raises alu_hold when a buffered result starves.
// Optional: define WB_PERF_EN to add the hold_cnt/conflict_cnt counters.
module wb_port_arbiter #(
  parameter int BUF_DEPTH  = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic             clk,
  input  logic             rstn,
  wb_port_arbiter_if.slave wb
`ifdef WB_PERF_EN
  ,
  output logic [15:0]      hold_cnt,
  output logic [15:0]      conflict_cnt
`endif
);

  localparam int PW   = $clog2(BUF_DEPTH);
  localparam int CW   = $clog2(BUF_DEPTH) + 1;
  localparam int SW   = $clog2(STARVE_MAX + 1);
  localparam int MULT = 0;
  localparam int LOAD = 1;

  typedef enum logic [1:0] {GNT_NONE, GNT_ALU, GNT_MULT, GNT_LOAD} grant_e;
  typedef enum logic {PRI_MULT, PRI_LOAD} pri_e;

  typedef struct packed {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        mult_wr;
    logic [4:0]  mult_rd;
    logic        load_wr;
    logic [4:0]  load_rd;
  } wb_out_t;

  logic          run;
  logic [1:0]    in_valid, push, pop, head_valid, full;
  logic [4:0]    in_rd     [2];
  logic [31:0]   in_data   [2];
  logic [4:0]    head_rd   [2];
  logic [31:0]   head_data [2];
  logic [4:0]    rd_mem    [2][BUF_DEPTH];
  logic [31:0]   data_mem  [2][BUF_DEPTH];
  logic [PW-1:0] wr_ptr    [2];
  logic [PW-1:0] rd_ptr    [2];
  logic [CW-1:0] count     [2];
  logic [SW-1:0] wait_q    [2];
  logic [SW-1:0] wait_d    [2];
  grant_e        grant;
  pri_e          pri_q;
  wb_out_t       out_d, out_q;
  logic          hold_d, hold_q;

  assign in_valid       = {wb.load_valid, wb.mult_valid};
  assign in_rd[MULT]    = wb.mult_rd;
  assign in_rd[LOAD]    = wb.load_rd;
  assign in_data[MULT]  = wb.mult_data;
  assign in_data[LOAD]  = wb.load_data;

  assign wb.mult_ready  = run & ~full[MULT];
  assign wb.load_ready  = run & ~full[LOAD];
  assign push           = in_valid & {wb.load_ready, wb.mult_ready};

  // Head status and head entry of each long-source FIFO.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    head_valid = '0;
    full       = '0;
    for (int i = 0; i < 2; i++) begin
      head_valid[i] = (count[i] != '0);
      full[i]       = (count[i] == CW'(BUF_DEPTH));
      head_rd[i]    = rd_mem[i][rd_ptr[i]];
      head_data[i]  = data_mem[i][rd_ptr[i]];
    end
  end

  // Ready outputs stay low while in reset and rise on the first clock after it.
  // NOTE: sequential state uses non-blocking (<=) so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) run <= 1'b0;
    else       run <= 1'b1;
  end

  // FIFO pointers and occupancy; push and pop together leave the count unchanged.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 2; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + PW'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PW'(1);
        case ({push[i], pop[i]})
          2'b10:   count[i] <= count[i] + CW'(1);
          2'b01:   count[i] <= count[i] - CW'(1);
          default: count[i] <= count[i];
        endcase
      end
    end
  end

  // FIFO storage: captures rd/data at the tail on each accepted transfer.
  // NOTE: storage has no reset; occupancy is tracked by count, so stale entries are never read.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (push[i]) begin
        rd_mem[i][wr_ptr[i]]   <= in_rd[i];
        data_mem[i][wr_ptr[i]] <= in_data[i];
      end
    end
  end

  // Arbitration (ALU first, then round-robin MULT/LOAD) and next output word.
  always_comb begin
    grant = GNT_NONE;
    pop   = '0;
    out_d = '0;
    if (wb.alu_wr)                        grant = GNT_ALU;
    else if (head_valid[MULT] && head_valid[LOAD])
      grant = (pri_q == PRI_MULT) ? GNT_MULT : GNT_LOAD;
    else if (head_valid[MULT])            grant = GNT_MULT;
    else if (head_valid[LOAD])            grant = GNT_LOAD;

    case (grant)
      GNT_ALU: begin
        out_d.we    = (wb.alu_rd != 5'd0);
        out_d.waddr = wb.alu_rd;
        out_d.wdata = wb.alu_data;
      end
      GNT_MULT: begin
        pop[MULT]     = 1'b1;
        out_d.we      = (head_rd[MULT] != 5'd0);
        out_d.waddr   = head_rd[MULT];
        out_d.wdata   = head_data[MULT];
        out_d.mult_wr = 1'b1;
        out_d.mult_rd = head_rd[MULT];
      end
      GNT_LOAD: begin
        pop[LOAD]     = 1'b1;
        out_d.we      = (head_rd[LOAD] != 5'd0);
        out_d.waddr   = head_rd[LOAD];
        out_d.wdata   = head_data[LOAD];
        out_d.load_wr = 1'b1;
        out_d.load_rd = head_rd[LOAD];
      end
      default: ;
    endcase
  end

  // Starvation counters: count denied cycles of a valid head, saturate, clear on grant.
  always_comb begin
    hold_d = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wait_d[i] = wait_q[i];
      if (pop[i])
        wait_d[i] = '0;
      else if (head_valid[i] && (wait_q[i] != SW'(STARVE_MAX)))
        wait_d[i] = wait_q[i] + SW'(1);
      if (wait_d[i] == SW'(STARVE_MAX)) hold_d = 1'b1;
    end
  end

  // Registered outputs, wait counters and round-robin pointer.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_q  <= '0;
      hold_q <= 1'b0;
      pri_q  <= PRI_MULT;
      for (int i = 0; i < 2; i++) wait_q[i] <= '0;
    end else begin
      out_q  <= out_d;
      hold_q <= hold_d;
      for (int i = 0; i < 2; i++) wait_q[i] <= wait_d[i];
      if (grant == GNT_MULT)      pri_q <= PRI_LOAD;
      else if (grant == GNT_LOAD) pri_q <= PRI_MULT;
    end
  end

  assign wb.rf_we       = out_q.we;
  assign wb.rf_waddr    = out_q.waddr;
  assign wb.rf_wdata    = out_q.wdata;
  assign wb.MULT_reg_wr = out_q.mult_wr;
  assign wb.MULT_reg_rd = out_q.mult_rd;
  assign wb.LOAD_reg_wr = out_q.load_wr;
  assign wb.LOAD_reg_rd = out_q.load_rd;
  assign wb.alu_hold    = hold_q;

`ifdef WB_PERF_EN
  // Saturating counters of hold cycles and ALU-vs-long-result conflicts.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hold_cnt     <= '0;
      conflict_cnt <= '0;
    end else begin
      if (hold_q && (hold_cnt != 16'hFFFF))
        hold_cnt <= hold_cnt + 16'd1;
      if (wb.alu_wr && (|head_valid) && (conflict_cnt != 16'hFFFF))
        conflict_cnt <= conflict_cnt + 16'd1;
    end
  end
`endif

endmodule
